// File: rtl/fp_div_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg
// Shared types and constants for the divider dispatch stage.
//   FP_W       : IEEE-754 single-precision word width
//   FP_QNAN    : quiet NaN returned when a request is abandoned on timeout
//   divState_t : dispatch FSM states
//   fp_pair_t  : one queued operand pair {dividend, divisor}
// -----------------------------------------------------------------------------
package fp_div_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } divState_t;

   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
   } fp_pair_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// -----------------------------------------------------------------------------
// fp_sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
//   clk, resetn : clock, asynchronous active-low reset (pointers/count only)
//   iPush/iData : write request; ignored while full
//   iPop/oData  : read request; oData always shows the head entry
//   oFull/oEmpty: status flags
//   oLevel      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fp_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     iPush,
   input  logic [WIDTH-1:0]         iData,
   input  logic                     iPop,
   output logic [WIDTH-1:0]         oData,
   output logic                     oFull,
   output logic                     oEmpty,
   output logic [$clog2(DEPTH):0]   oLevel
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign oFull  = (count == (AW+1)'(DEPTH));
   assign oEmpty = (count == '0);
   // Fullness alone gates a push: a same-cycle pop does not make room.
   assign doPush = iPush && !oFull;
   assign doPop  = iPop && !oEmpty;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= iData;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign oData  = mem[rdPtr];
   assign oLevel = count;

endmodule

// File: rtl/fp_div_dispatch.sv
// -----------------------------------------------------------------------------
// fp_div_dispatch
// Issue stage in front of float_point_divide. Queues operand pairs, issues one
// at a time as a single-cycle pulse, waits for done (or gives up after TIMEOUT
// WAIT cycles) and returns quotients in request order.
//   clk, resetn           : clock, asynchronous active-low reset
//   iReqValid/oReqReady   : request handshake, operands iReqA / iReqB
//   oDivA/oDivB/oDivValid : operands and issue pulse to the divider
//   iDivDone/iDivZ        : divider completion strobe and quotient
//   oRspValid/iRspReady   : response handshake, oRspZ quotient, oRspErr timeout
//   oBusy                 : FSM not idle or queue not empty
//   oLevel                : queue occupancy
// -----------------------------------------------------------------------------
module fp_div_dispatch
   import fp_div_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     iReqValid,
   output logic                     oReqReady,
   input  logic [FP_W-1:0]          iReqA,
   input  logic [FP_W-1:0]          iReqB,
   output logic [FP_W-1:0]          oDivA,
   output logic [FP_W-1:0]          oDivB,
   output logic                     oDivValid,
   input  logic                     iDivDone,
   input  logic [FP_W-1:0]          iDivZ,
   output logic                     oRspValid,
   input  logic                     iRspReady,
   output logic [FP_W-1:0]          oRspZ,
   output logic                     oRspErr,
   output logic                     oBusy,
   output logic [$clog2(DEPTH):0]   oLevel
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   divState_t       state;
   divState_t       stateNext;
   logic [TW-1:0]   tmoCnt;
   logic [TW-1:0]   tmoCntNext;
   logic [FP_W-1:0] divANext;
   logic [FP_W-1:0] divBNext;
   logic            divValidNext;
   logic            rspValidNext;
   logic [FP_W-1:0] rspZNext;
   logic            rspErrNext;

   fp_pair_t reqPair;
   fp_pair_t headPair;
   logic     fifoFull;
   logic     fifoEmpty;
   logic     fifoPop;

   assign reqPair.a = iReqA;
   assign reqPair.b = iReqB;

   fp_sync_fifo #(
      .WIDTH ($bits(fp_pair_t)),
      .DEPTH (DEPTH)
   ) uFifo (
      .clk    (clk),
      .resetn (resetn),
      .iPush  (iReqValid && oReqReady),
      .iData  (reqPair),
      .iPop   (fifoPop),
      .oData  (headPair),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty),
      .oLevel (oLevel)
   );

   assign oReqReady = !fifoFull;
   assign oBusy     = (state != IDLE) || !fifoEmpty;

   always_comb begin
      stateNext    = state;
      tmoCntNext   = tmoCnt;
      divANext     = oDivA;
      divBNext     = oDivB;
      divValidNext = 1'b0;      // issue strobe lasts exactly one cycle
      rspValidNext = oRspValid;
      rspZNext     = oRspZ;
      rspErrNext   = oRspErr;
      fifoPop      = 1'b0;

      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               fifoPop      = 1'b1;
               divANext     = headPair.a;
               divBNext     = headPair.b;
               divValidNext = 1'b1;
               tmoCntNext   = '0;
               stateNext    = WAIT;
            end
         end
         WAIT: begin
            // Done wins over timeout, even in the issue-pulse cycle.
            if (iDivDone) begin
               rspZNext     = iDivZ;
               rspErrNext   = 1'b0;
               rspValidNext = 1'b1;
               stateNext    = RESP;
            end else if (tmoCnt == T_LAST) begin
               rspZNext     = FP_QNAN;
               rspErrNext   = 1'b1;
               rspValidNext = 1'b1;
               stateNext    = RESP;
            end else begin
               tmoCntNext = tmoCnt + 1'b1;
            end
         end
         RESP: begin
            if (iRspReady) begin
               rspValidNext = 1'b0;
               stateNext    = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         tmoCnt    <= '0;
         oDivA     <= '0;
         oDivB     <= '0;
         oDivValid <= 1'b0;
         oRspValid <= 1'b0;
         oRspZ     <= '0;
         oRspErr   <= 1'b0;
      end else begin
         state     <= stateNext;
         tmoCnt    <= tmoCntNext;
         oDivA     <= divANext;
         oDivB     <= divBNext;
         oDivValid <= divValidNext;
         oRspValid <= rspValidNext;
         oRspZ     <= rspZNext;
         oRspErr   <= rspErrNext;
      end
   end

endmodule

// File: tb/tb_fp_div_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fp_div_dispatch
// Self-checking bench for fp_div_dispatch with a behavioural divider model
// whose quotient and latency per issue come from queues filled by the tests.
// -----------------------------------------------------------------------------
module tb_fp_div_dispatch;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iReqValid = 1'b0;
   logic        oReqReady;
   logic [31:0] iReqA = '0;
   logic [31:0] iReqB = '0;
   logic [31:0] oDivA;
   logic [31:0] oDivB;
   logic        oDivValid;
   logic        iDivDone = 1'b0;
   logic [31:0] iDivZ = '0;
   logic        oRspValid;
   logic        iRspReady = 1'b0;
   logic [31:0] oRspZ;
   logic        oRspErr;
   logic        oBusy;
   logic [2:0]  oLevel;

   fp_div_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .iReqValid (iReqValid),
      .oReqReady (oReqReady),
      .iReqA     (iReqA),
      .iReqB     (iReqB),
      .oDivA     (oDivA),
      .oDivB     (oDivB),
      .oDivValid (oDivValid),
      .iDivDone  (iDivDone),
      .iDivZ     (iDivZ),
      .oRspValid (oRspValid),
      .iRspReady (iRspReady),
      .oRspZ     (oRspZ),
      .oRspErr   (oRspErr),
      .oBusy     (oBusy),
      .oLevel    (oLevel)
   );

   always #5 clk = ~clk;

   int cmpCount  = 0;
   int failCount = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      int          lat;
   } vec_t;

   // ---------------- divider model (drives on falling edges) ----------------
   logic [31:0] zQ[$];
   int          latQ[$];
   logic        hold = 1'b0;
   logic        neverDone = 1'b0;
   logic        forceDone = 1'b0;
   int          cd = 0;
   logic        busyM = 1'b0;
   logic [31:0] curZ = '0;
   int          curLat = 0;

   always @(negedge clk) begin
      if (!resetn) begin
         iDivDone = 1'b0;
         busyM    = 1'b0;
         cd       = 0;
      end else begin
         iDivDone = 1'b0;
         if (forceDone) begin
            iDivDone  = 1'b1;
            iDivZ     = 32'hDEADBEEF;
            forceDone = 1'b0;
         end else if (oDivValid) begin
            curZ   = 32'h0;
            curLat = 3;
            if (zQ.size() > 0) curZ = zQ.pop_front();
            if (latQ.size() > 0) curLat = latQ.pop_front();
            if (neverDone) begin
               busyM = 1'b0;
            end else if (curLat == 0) begin
               iDivDone = 1'b1;
               iDivZ    = curZ;
            end else begin
               cd    = curLat;
               busyM = 1'b1;
            end
         end else if (busyM && !hold) begin
            cd = cd - 1;
            if (cd == 0) begin
               iDivDone = 1'b1;
               iDivZ    = curZ;
               busyM    = 1'b0;
            end
         end
      end
   end

   // ---------------- issue/response monitor (rising edges) ----------------
   int          pulses = 0;
   int          overlap = 0;
   logic        outstanding = 1'b0;
   logic [63:0] issuedQ[$];

   always @(posedge clk) begin
      if (!resetn) begin
         outstanding = 1'b0;
      end else begin
         if (oDivValid) begin
            pulses = pulses + 1;
            if (outstanding) overlap = overlap + 1;
            outstanding = 1'b1;
            issuedQ.push_back({oDivA, oDivB});
         end
         if (oRspValid && iRspReady) outstanding = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmpCount++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic boundFail(input string name);
      cmpCount++;
      failCount++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic pushPair(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!oReqReady && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) boundFail("push_ready");
      iReqValid = 1'b1;
      iReqA     = a;
      iReqB     = b;
      @(negedge clk);
      iReqValid = 1'b0;
      $display("push a=%h b=%h", a, b);
   endtask

   task automatic waitPulse(input string name, output int n);
      n = 0;
      while (!oDivValid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) boundFail(name);
   endtask

   task automatic getRsp(input string name, input logic [31:0] expZ, input logic expErr);
      int n = 0;
      while (!oRspValid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         boundFail(name);
      end else begin
         check({name, " z"}, oRspZ, expZ);
         check({name, " err"}, 32'(oRspErr), 32'(expErr));
         $display("rsp %s: z=%h err=%b", name, oRspZ, oRspErr);
      end
      iRspReady = 1'b1;
      @(negedge clk);
      iRspReady = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- tests ----------------
   initial begin
      vec_t tab3[3];
      vec_t tab2[8];
      logic [31:0] z5[5];
      int n;
      int k;
      int p0;
      int bad;

      tab3[0] = '{a:32'h40800000, b:32'h40000000, z:32'h40000000, lat:0};
      tab3[1] = '{a:32'hC1000000, b:32'h40000000, z:32'hC0800000, lat:5};
      tab3[2] = '{a:32'h3F800000, b:32'h40800000, z:32'h3E800000, lat:2};
      for (int i = 0; i < 8; i++) begin
         tab2[i] = '{a:32'h41000000 + 32'(i), b:32'h40000000 + 32'(i), z:32'h3F800000 + 32'(i), lat:2};
      end
      for (int i = 0; i < 5; i++) z5[i] = 32'h42000000 + 32'(i);

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst oReqReady", 32'(oReqReady), 1);
      check("rst oDivValid", 32'(oDivValid), 0);
      check("rst oRspValid", 32'(oRspValid), 0);
      check("rst oBusy", 32'(oBusy), 0);
      check("rst oLevel", 32'(oLevel), 0);
      check("rst oDivA", oDivA, 0);
      check("rst oRspZ", oRspZ, 0);
      resetn = 1'b1;
      @(negedge clk);

      // ---- 1: single operation, latency 10 ----
      p0 = pulses;
      zQ.push_back(32'h40400000);
      latQ.push_back(10);
      pushPair(32'h3FC00000, 32'h3F000000);
      waitPulse("t1 pulse", n);
      check("t1 issue latency", 32'(n), 1);
      check("t1 oDivA", oDivA, 32'h3FC00000);
      check("t1 oDivB", oDivB, 32'h3F000000);
      n = 0;
      while (!oRspValid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t1 rsp latency", 32'(n), 11);
      getRsp("t1", 32'h40400000, 1'b0);
      check("t1 oRspValid after hs", 32'(oRspValid), 0);
      check("t1 oBusy after hs", 32'(oBusy), 0);
      check("t1 pulse count", 32'(pulses - p0), 1);

      // ---- 2: stalled divider, fill the queue ----
      p0 = pulses;
      issuedQ.delete();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         zQ.push_back(tab2[i].z);
         latQ.push_back(tab2[i].lat);
      end
      k = 0;
      iReqValid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         iReqA = tab2[k].a;
         iReqB = tab2[k].b;
         if (oReqReady) k++;
         @(negedge clk);
      end
      iReqValid = 1'b0;
      check("t2 accepted", 32'(k), 5);
      check("t2 oReqReady", 32'(oReqReady), 0);
      check("t2 oLevel", 32'(oLevel), 4);
      check("t2 pulses while stalled", 32'(pulses - p0), 1);
      hold = 1'b0;
      for (int i = 0; i < 5; i++) getRsp($sformatf("t2[%0d]", i), tab2[i].z, 1'b0);
      check("t2 issued count", 32'(issuedQ.size()), 5);
      for (int i = 0; i < 5 && i < issuedQ.size(); i++) begin
         check($sformatf("t2 issued a[%0d]", i), issuedQ[i][63:32], tab2[i].a);
         check($sformatf("t2 issued b[%0d]", i), issuedQ[i][31:0], tab2[i].b);
      end

      // ---- 3: table of three operations, varied latency ----
      issuedQ.delete();
      overlap = 0;
      for (int i = 0; i < 3; i++) begin
         zQ.push_back(tab3[i].z);
         latQ.push_back(tab3[i].lat);
         pushPair(tab3[i].a, tab3[i].b);
      end
      for (int i = 0; i < 3; i++) getRsp($sformatf("t3[%0d]", i), tab3[i].z, 1'b0);
      check("t3 overlapping issues", 32'(overlap), 0);
      for (int i = 0; i < 3 && i < issuedQ.size(); i++) begin
         check($sformatf("t3 issued a[%0d]", i), issuedQ[i][63:32], tab3[i].a);
      end

      // ---- 4: timeout, then the queued pair issues ----
      neverDone = 1'b1;
      zQ.push_back(32'h0);
      latQ.push_back(1);
      pushPair(32'h11111111, 32'h22222222);
      pushPair(32'h33333333, 32'h44444444);
      waitPulse("t4 pulse X", n);
      check("t4 oDivA X", oDivA, 32'h11111111);
      n = 0;
      bad = 0;
      while (!oRspValid && n < 300) begin
         @(negedge clk);
         n++;
         if (oDivValid) bad++;
      end
      check("t4 timeout cycles", 32'(n), 64);
      check("t4 pulses during wait", 32'(bad), 0);
      neverDone = 1'b0;
      zQ.push_back(32'h3F400000);
      latQ.push_back(2);
      getRsp("t4 timeout", 32'h7FC00000, 1'b1);
      waitPulse("t4 pulse Y", n);
      check("t4 Y issue delay", 32'(n), 1);
      check("t4 oDivA Y", oDivA, 32'h33333333);
      getRsp("t4 Y", 32'h3F400000, 1'b0);

      // ---- 5: response back-pressure while the queue fills ----
      zQ.push_back(z5[0]);
      latQ.push_back(2);
      for (int i = 1; i < 5; i++) begin
         zQ.push_back(z5[i]);
         latQ.push_back(2);
      end
      pushPair(32'h50000000, 32'h50000001);
      n = 0;
      while (!oRspValid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) boundFail("t5 first rsp");
      k = 0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (oRspZ !== z5[0] || oRspErr !== 1'b0 || oRspValid !== 1'b1 || oDivValid !== 1'b0) bad++;
         iReqValid = oReqReady && (k < 4);
         iReqA = 32'h50000010 + 32'(k);
         iReqB = 32'h50000020 + 32'(k);
         if (iReqValid) k++;
         @(negedge clk);
      end
      iReqValid = 1'b0;
      check("t5 unstable cycles", 32'(bad), 0);
      check("t5 oLevel", 32'(oLevel), 4);
      check("t5 oReqReady", 32'(oReqReady), 0);
      for (int i = 0; i < 5; i++) getRsp($sformatf("t5[%0d]", i), z5[i], 1'b0);

      // ---- 6: asynchronous reset mid-WAIT ----
      p0 = pulses;
      hold = 1'b1;
      zQ.push_back(32'h12345678);
      latQ.push_back(5);
      pushPair(32'h60000000, 32'h60000001);
      pushPair(32'h60000002, 32'h60000003);
      repeat (2) @(negedge clk);
      check("t6 pre-reset oLevel", 32'(oLevel), 1);
      check("t6 pre-reset oBusy", 32'(oBusy), 1);
      #2;
      resetn = 1'b0;
      #1;
      check("t6 async oDivA", oDivA, 0);
      check("t6 async oDivB", oDivB, 0);
      check("t6 async oRspZ", oRspZ, 0);
      check("t6 async oRspValid", 32'(oRspValid), 0);
      check("t6 async oRspErr", 32'(oRspErr), 0);
      check("t6 async oBusy", 32'(oBusy), 0);
      check("t6 async oLevel", 32'(oLevel), 0);
      check("t6 async oReqReady", 32'(oReqReady), 1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      hold = 1'b0;
      zQ.delete();
      latQ.delete();
      p0 = pulses;
      forceDone = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (oRspValid || oDivValid) bad++;
      end
      check("t6 late done ignored", 32'(bad), 0);
      check("t6 no issues after reset", 32'(pulses - p0), 0);
      check("t6 idle after reset", 32'(oBusy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
